cordic_iterative_gen: RTL and testbench

Parametrised iterative CORDIC engine: one shared micro-rotation datapath reused for ITERATIONS cycles per transaction. It succeeds the fixed 8-bit rotation-only engine and adds four features: configurable width and iteration count, a per-transaction rotation/vectoring mode, guard bits with output saturation, and a ready/valid handshake with backpressure on both sides. It sits between the sample front-end and the NCO/phase-detector consumers.

---
 rtl/cordic_pkg.sv | 61 ++++++
 rtl/cordic_micro_rotation.sv | 60 ++++++
 rtl/cordic_iterative_gen.sv | 196 +++++++++++++++++++
 tb/tb_cordic_iterative_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg - shared definitions for the iterative CORDIC engine.
// Holds the FSM state encoding, the operating-mode encoding, the
// arctangent table generator and the output saturation helper.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  localparam real CORDIC_PI = 3.14159265358979323846;

  // floor(atan(2^-i) * 2^n_frac / pi), evaluated at elaboration time only.
  // i = 0 is returned exactly because atan(1) = pi/4 lands on an integer
  // and a floating-point series could fall just below it.
  function automatic int cordic_atan(input int i, input int n_frac);
    real t;
    real p;
    real acc;
    real scale;
    if (i == 0) begin
      return (1 << n_frac) / 4;
    end
    t = 1.0;
    for (int k = 0; k < i; k++) begin
      t = t / 2.0;
    end
    scale = 1.0;
    for (int k = 0; k < n_frac; k++) begin
      scale = scale * 2.0;
    end
    acc = 0.0;
    p   = t;
    for (int k = 0; k < 30; k++) begin
      acc = acc + (((k % 2) != 0) ? -1.0 : 1.0) * p / real'(2 * k + 1);
      p   = p * t * t;
    end
    return $rtoi(acc * scale / CORDIC_PI);
  endfunction

  // Clamp a value to the signed output range [-2^n_frac, 2^n_frac - 1].
  function automatic int cordic_sat(input int v, input int n_frac);
    int hi;
    int lo;
    hi = (1 << n_frac) - 1;
    lo = -(1 << n_frac);
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/cordic_micro_rotation.sv
// cordic_micro_rotation - one combinational CORDIC micro-rotation step.
// The engine reuses this single instance for every iteration; the shift
// amount selects both the arithmetic shift and the arctangent constant.
module cordic_micro_rotation
  import cordic_pkg::*;
#(
  parameter int N_FRAC     = 7,
  parameter int ITERATIONS = 6,
  parameter int W          = 8,
  parameter int XW         = 10,
  parameter int CW         = 3
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [W-1:0]  z_i,
  input  logic                 mode_i,
  input  logic [CW-1:0]        shift_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [W-1:0]  z_o
);

  logic signed [W-1:0]  atan_tab [ITERATIONS];
  logic signed [W-1:0]  atan_sel;
  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic                 dir_pos;

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    localparam logic signed [W-1:0] ATAN_G = W'(cordic_atan(g, N_FRAC));
    assign atan_tab[g] = ATAN_G;
  end

  // Pick the arctangent constant for the current iteration.
  always_comb begin
    atan_sel = '0;
    for (int k = 0; k < ITERATIONS; k++) begin
      if (shift_i == CW'(k)) begin
        atan_sel = atan_tab[k];
      end
    end
  end

  // Choose the rotation direction and apply one shift-add step; z wraps.
  always_comb begin
    dir_pos = (mode_i == MODE_ROT) ? !z_i[W-1] : y_i[XW-1];
    x_sh    = x_i >>> shift_i;
    y_sh    = y_i >>> shift_i;
    if (dir_pos) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_sel;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_sel;
    end
  end

endmodule

// File: rtl/cordic_iterative_gen.sv
// cordic_iterative_gen - iterative CORDIC engine with ready/valid on both
// sides, rotation/vectoring mode per transaction, guard bits on x/y and
// saturated x/y outputs. Define CORDIC_QUADRANT_CORR_EN to add the PRE
// state that pre-rotates by +-pi/2 for full-circle convergence.
module cordic_iterative_gen
  import cordic_pkg::*;
#(
  parameter int N_FRAC     = 7,
  parameter int ITERATIONS = 6,
  parameter int GUARD      = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_FRAC:0] x_i,
  input  logic [N_FRAC:0] y_i,
  input  logic [N_FRAC:0] z_i,
  input  logic            mode_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic [N_FRAC:0] x_o,
  output logic [N_FRAC:0] y_o,
  output logic [N_FRAC:0] z_o,
  output logic            out_valid_o,
  input  logic            out_ready_i
);

  localparam int W  = N_FRAC + 1;
  localparam int XW = W + GUARD;
  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

`ifdef CORDIC_QUADRANT_CORR_EN
  localparam state_e ST_FIRST = ST_PRE;
  localparam logic signed [W-1:0] Z_QTR = W'(1 << (N_FRAC - 1));
`else
  localparam state_e ST_FIRST = ST_CALC;
`endif

  state_e               state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [W-1:0]  z_q, z_d;
  logic                 mode_q, mode_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic signed [XW-1:0] x_rot, y_rot;
  logic signed [W-1:0]  z_rot;
  logic                 accept;
  logic                 last_iter;

  cordic_micro_rotation #(
    .N_FRAC    (N_FRAC),
    .ITERATIONS(ITERATIONS),
    .W         (W),
    .XW        (XW),
    .CW        (CW)
  ) u_micro (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .mode_i (mode_q),
    .shift_i(cnt_q),
    .x_o    (x_rot),
    .y_o    (y_rot),
    .z_o    (z_rot)
  );

`ifdef CORDIC_QUADRANT_CORR_EN
  logic signed [XW-1:0] x_pre, y_pre;
  logic signed [W-1:0]  z_pre;

  // Quarter-turn pre-rotation that brings the operand into the CORDIC convergence range.
  always_comb begin
    x_pre = x_q;
    y_pre = y_q;
    z_pre = z_q;
    if (mode_q == MODE_ROT) begin
      if (z_q > Z_QTR) begin
        x_pre = -y_q;
        y_pre = x_q;
        z_pre = z_q - Z_QTR;
      end else if (z_q < -Z_QTR) begin
        x_pre = y_q;
        y_pre = -x_q;
        z_pre = z_q + Z_QTR;
      end
    end else if (x_q < 0) begin
      if (y_q >= 0) begin
        x_pre = y_q;
        y_pre = -x_q;
        z_pre = z_q + Z_QTR;
      end else begin
        x_pre = -y_q;
        y_pre = x_q;
        z_pre = z_q - Z_QTR;
      end
    end
  end
`endif

  // State register and datapath flops; reset aborts any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= MODE_ROT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, including the DONE-to-CALC shortcut when a new operand waits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          state_d = ST_FIRST;
        end
      end
`ifdef CORDIC_QUADRANT_CORR_EN
      ST_PRE: begin
        state_d = ST_CALC;
      end
`endif
      ST_CALC: begin
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = in_valid_i ? ST_FIRST : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    out_valid_o = (state_q == ST_DONE);
    in_ready_o  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
    accept      = in_valid_i && in_ready_o;
    last_iter   = (cnt_q == CW'(ITERATIONS - 1));
  end

  // Datapath updates: load on accept, pre-rotate in PRE, one micro-rotation per CALC cycle.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    if (accept) begin
      x_d    = {{GUARD{x_i[W-1]}}, x_i};
      y_d    = {{GUARD{y_i[W-1]}}, y_i};
      z_d    = z_i;
      mode_d = mode_i;
      cnt_d  = '0;
    end else begin
      case (state_q)
`ifdef CORDIC_QUADRANT_CORR_EN
        ST_PRE: begin
          x_d = x_pre;
          y_d = y_pre;
          z_d = z_pre;
        end
`endif
        ST_CALC: begin
          x_d = x_rot;
          y_d = y_rot;
          z_d = z_rot;
          if (!last_iter) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign x_o = W'(cordic_sat(int'(x_q), N_FRAC));
  assign y_o = W'(cordic_sat(int'(y_q), N_FRAC));
  assign z_o = z_q;

endmodule

// File: tb/tb_cordic_iterative_gen.sv
// tb_cordic_iterative_gen - directed self-checking bench for the iterative
// CORDIC engine (N_FRAC=7, ITERATIONS=6, GUARD=2). Honours
// CORDIC_QUADRANT_CORR_EN for the expected latency and pre-rotation.
module tb_cordic_iterative_gen;

  localparam int N_FRAC = 7;
  localparam int ITERS  = 6;
  localparam int GUARD  = 2;
`ifdef CORDIC_QUADRANT_CORR_EN
  localparam int LAT = ITERS + 1;
`else
  localparam int LAT = ITERS;
`endif

  typedef struct {
    int    x;
    int    y;
    int    z;
    bit    dc;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] x_i, y_i, z_i;
  logic       mode_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] x_o, y_o, z_o;
  logic       out_valid_o;
  logic       out_ready_i;

  int   check_cnt = 0;
  int   pass_cnt  = 0;
  exp_t exp_q[$];

  cordic_iterative_gen #(
    .N_FRAC    (N_FRAC),
    .ITERATIONS(ITERS),
    .GUARD     (GUARD)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .x_i        (x_i),
    .y_i        (y_i),
    .z_i        (z_i),
    .mode_i     (mode_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .x_o        (x_o),
    .y_o        (y_o),
    .z_o        (z_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  always #5 clk = ~clk;

  // Angle arithmetic wraps modulo 256 into [-128, 127].
  function automatic int wrapZ(input int v);
    int m;
    m = v & 255;
    return (m >= 128) ? m - 256 : m;
  endfunction

  function automatic int clip(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference CORDIC computed on plain integers straight from the algorithm definition.
  function automatic void cordicModel(input int xi, input int yi, input int zi, input bit vec,
                                      output int xo, output int yo, output int zo);
    int atan_tab [6];
    int x, y, z, xn, yn;
    bit pos;
    atan_tab = '{32, 18, 9, 5, 2, 1};
    x = xi;
    y = yi;
    z = zi;
`ifdef CORDIC_QUADRANT_CORR_EN
    if (!vec) begin
      if (z > 64) begin xn = -y; yn = x; z = wrapZ(z - 64); x = xn; y = yn; end
      else if (z < -64) begin xn = y; yn = -x; z = wrapZ(z + 64); x = xn; y = yn; end
    end else if (x < 0) begin
      if (y >= 0) begin xn = y; yn = -x; z = wrapZ(z + 64); x = xn; y = yn; end
      else begin xn = -y; yn = x; z = wrapZ(z - 64); x = xn; y = yn; end
    end
`endif
    for (int i = 0; i < 6; i++) begin
      pos = vec ? (y < 0) : (z >= 0);
      if (pos) begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
        z  = wrapZ(z - atan_tab[i]);
      end else begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
        z  = wrapZ(z + atan_tab[i]);
      end
      x = xn;
      y = yn;
    end
    xo = clip(x);
    yo = clip(y);
    zo = z;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one operand set and hold it until the engine takes it; queue the expected result.
  task automatic applyStimulus(input string name, input int xv, input int yv, input int zv,
                               input bit vec, input bit dc);
    bit   accepted;
    bit   ready_seen;
    exp_t e;
    x_i        = 8'(xv);
    y_i        = 8'(yv);
    z_i        = 8'(zv);
    mode_i     = vec;
    in_valid_i = 1'b1;
    accepted   = 1'b0;
    for (int n = 0; n < 100 && !accepted; n++) begin
      @(negedge clk);
      ready_seen = in_ready_o;
      @(posedge clk);
      #1;
      if (ready_seen) accepted = 1'b1;
    end
    in_valid_i = 1'b0;
    checkOutput({name, "_accept"}, int'(accepted), 1);
    cordicModel(xv, yv, zv, vec, e.x, e.y, e.z);
    e.dc   = dc;
    e.name = name;
    if (accepted) exp_q.push_back(e);
  endtask

  // Count edges from the accept edge until out_valid_o rises.
  task automatic waitResult(input string name);
    int lat;
    bit seen;
    lat  = -1;
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (out_valid_o) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    checkOutput({name, "_latency"}, lat, LAT);
  endtask

  // Compare every valid result cycle against the model; pop when the consumer takes it.
  always @(negedge clk) begin
    if (!rst_i && out_valid_o) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        if (!exp_q[0].dc) begin
          checkOutput({exp_q[0].name, "_x"}, int'($signed(x_o)), exp_q[0].x);
          checkOutput({exp_q[0].name, "_y"}, int'($signed(y_o)), exp_q[0].y);
          checkOutput({exp_q[0].name, "_z"}, int'($signed(z_o)), exp_q[0].z);
        end
        if (out_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int mx, my, mz;
    int vx [6];
    int vy [6];
    int vz [6];
    bit vm [6];
    bit vdc [6];
    bit stray;

    vx  = '{64, 64, 64, -120, 50, 100};
    vy  = '{ 0,  0, 64,    0, -40, -50};
    vz  = '{ 0, 64,  0,    0, -30,   0};
    vm  = '{ 0,  0,  1,    0,   0,   1};
    vdc = '{ 0,  0,  0,    0,   0,   0};

    rst_i       = 1'b1;
    x_i         = '0;
    y_i         = '0;
    z_i         = '0;
    mode_i      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", int'(out_valid_o), 0);
    checkOutput("reset_in_ready", int'(in_ready_o), 1);
    checkOutput("reset_x", int'(x_o), 0);
    checkOutput("reset_y", int'(y_o), 0);
    checkOutput("reset_z", int'(z_o), 0);
    rst_i = 1'b0;

    cordicModel(64, 0, 0, 1'b0, mx, my, mz);
    checkOutput("pin_rot0_x", mx, 106);
    checkOutput("pin_rot0_y", my, -2);
    checkOutput("pin_rot0_z", mz, -1);
    cordicModel(64, 0, 64, 1'b0, mx, my, mz);
    checkOutput("pin_rot90_x", mx, -8);
    checkOutput("pin_rot90_y", my, 105);
    cordicModel(64, 64, 0, 1'b1, mx, my, mz);
    checkOutput("pin_vec45_x", mx, 127);
    checkOutput("pin_vec45_y", my, -1);
    checkOutput("pin_vec45_z", mz, 33);
    cordicModel(-120, 0, 0, 1'b0, mx, my, mz);
    checkOutput("pin_negsat_x", mx, -128);
`ifdef CORDIC_QUADRANT_CORR_EN
    cordicModel(64, 0, 96, 1'b0, mx, my, mz);
    checkOutput("pin_rot135_x", mx, -75);
    checkOutput("pin_rot135_y", my, 76);
`endif

    for (int v = 0; v < 6; v++) begin
      applyStimulus($sformatf("vec%0d", v), vx[v], vy[v], vz[v], vm[v], vdc[v]);
      waitResult($sformatf("vec%0d", v));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_idle_valid", v), int'(out_valid_o), 0);
      checkOutput($sformatf("vec%0d_idle_ready", v), int'(in_ready_o), 1);
    end

`ifdef CORDIC_QUADRANT_CORR_EN
    applyStimulus("rot135", 64, 0, 96, 1'b0, 1'b0);
`else
    applyStimulus("rot135", 64, 0, 96, 1'b0, 1'b1);
`endif
    waitResult("rot135");
    @(posedge clk);
    #1;

    out_ready_i = 1'b0;
    applyStimulus("bp", 64, 0, 0, 1'b0, 1'b0);
    waitResult("bp");
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_in_ready", int'(in_ready_o), 0);
      checkOutput("bp_valid_hold", int'(out_valid_o), 1);
      @(posedge clk);
      #1;
    end
    out_ready_i = 1'b1;
    applyStimulus("b2b", 64, 64, 0, 1'b1, 1'b0);
    checkOutput("b2b_valid_low", int'(out_valid_o), 0);
    checkOutput("b2b_no_idle", int'(in_ready_o), 0);
    waitResult("b2b");
    @(posedge clk);
    #1;

    applyStimulus("abort", 64, 0, 64, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_i = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    checkOutput("abort_out_valid", int'(out_valid_o), 0);
    checkOutput("abort_in_ready", int'(in_ready_o), 1);
    checkOutput("abort_x", int'(x_o), 0);
    checkOutput("abort_y", int'(y_o), 0);
    checkOutput("abort_z", int'(z_o), 0);
    rst_i = 1'b0;
    stray = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid_o) stray = 1'b1;
    end
    checkOutput("abort_no_result", int'(stray), 0);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
